idli_fetch_m: RTL and testbench



---
 rtl/idli_fetch_m.sv | 198 +++++++++++++++++++
 tb/tb_idli_fetch_m.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_fetch_m.sv
// ---------------------------------------------------------------------------
// idli_fetch_m -- instruction fetch stage
//
// Reads instruction words from an external SQI SRAM in sequential read mode
// and streams them to the decoder one nibble per cycle, MSB nibble first.
// A burst is opened once (command + 24-bit byte address + dummy cycles) and
// then left running; only a redirect or reset closes it and opens a new one.
//
// Ports
//   i_fch_gck          clock
//   i_fch_rst          synchronous active-high reset
//   o_fch_sqi_cs_n     SRAM chip select, active low
//   o_fch_sqi_sck_en   SCK gate, SRAM is clocked in cycles where this is 1
//   o_fch_sqi_oe       1 = block drives SIO
//   o_fch_sqi_wr       nibble driven onto SIO
//   i_fch_sqi_rd       nibble sampled from SIO
//   o_fch_enc          nibble to decode
//   o_fch_enc_vld      o_fch_enc valid
//   o_fch_pc           word address of the word o_fch_enc belongs to
//   i_fch_stall        backend cannot accept nibbles, freeze
//   i_fch_redirect     execute redirect
//   i_fch_redirect_pc  redirect target word address
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_DESEL | chip deselected for one cycle, closes any open burst
// ST_CMD   | two nibbles of the read command
// ST_ADDR  | six nibbles of the byte address
// ST_DUMMY | turnaround cycles before the SRAM drives data
// ST_DATA  | one data nibble sampled per SCK cycle, indefinitely
// ---------------------------------------------------------------------------
module idli_fetch_m #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [7:0]  READ_CMD     = 8'h03,
    parameter int unsigned DUMMY_CYCLES = 2
) (
    input  logic        i_fch_gck,
    input  logic        i_fch_rst,
    output logic        o_fch_sqi_cs_n,
    output logic        o_fch_sqi_sck_en,
    output logic        o_fch_sqi_oe,
    output logic [3:0]  o_fch_sqi_wr,
    input  logic [3:0]  i_fch_sqi_rd,
    output logic [3:0]  o_fch_enc,
    output logic        o_fch_enc_vld,
    output logic [15:0] o_fch_pc,
    input  logic        i_fch_stall,
    input  logic        i_fch_redirect,
    input  logic [15:0] i_fch_redirect_pc
);

    typedef enum logic [2:0] {
        ST_DESEL,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA
    } state_t;

    localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  nib_cnt_q, nib_cnt_d;
    logic [1:0]  wrd_cnt_q, wrd_cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] pc_q, pc_d;
    logic [3:0]  enc_q, enc_d;
    logic        vld_q, vld_d;
    logic [23:0] byte_addr;
    logic [23:0] addr_shift;

    // SRAM is byte addressed; instruction words are 16 bits.
    assign byte_addr  = {7'b0, addr_q, 1'b0};
    // Address nibble 5 (MSB) goes out first, so shift by 4*(5-cnt).
    assign addr_shift = byte_addr >> {3'd5 - nib_cnt_q[2:0], 2'b00};

    always_ff @(posedge i_fch_gck) begin
        if (i_fch_rst) begin
            state_q   <= ST_DESEL;
            nib_cnt_q <= 4'd0;
            wrd_cnt_q <= 2'd0;
            addr_q    <= RESET_PC;
            pc_q      <= RESET_PC;
            enc_q     <= 4'h0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            nib_cnt_q <= nib_cnt_d;
            wrd_cnt_q <= wrd_cnt_d;
            addr_q    <= addr_d;
            pc_q      <= pc_d;
            enc_q     <= enc_d;
            vld_q     <= vld_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        nib_cnt_d = nib_cnt_q;
        wrd_cnt_d = wrd_cnt_q;
        addr_d    = addr_q;
        pc_d      = pc_q;
        enc_d     = enc_q;
        vld_d     = 1'b0;

        o_fch_sqi_cs_n   = 1'b1;
        o_fch_sqi_sck_en = 1'b0;
        o_fch_sqi_oe     = 1'b0;
        o_fch_sqi_wr     = 4'h0;

        case (state_q)
            ST_DESEL: begin
                // Stall is deliberately ignored here: nothing is clocked yet.
                state_d   = ST_CMD;
                nib_cnt_d = 4'd0;
                wrd_cnt_d = 2'd0;
            end
            ST_CMD: begin
                o_fch_sqi_cs_n = 1'b0;
                o_fch_sqi_oe   = 1'b1;
                o_fch_sqi_wr   = nib_cnt_q[0] ? READ_CMD[3:0] : READ_CMD[7:4];
                if (!i_fch_stall) begin
                    o_fch_sqi_sck_en = 1'b1;
                    if (nib_cnt_q == 4'd1) begin
                        state_d   = ST_ADDR;
                        nib_cnt_d = 4'd0;
                    end else begin
                        nib_cnt_d = nib_cnt_q + 4'd1;
                    end
                end
            end
            ST_ADDR: begin
                o_fch_sqi_cs_n = 1'b0;
                o_fch_sqi_oe   = 1'b1;
                o_fch_sqi_wr   = addr_shift[3:0];
                if (!i_fch_stall) begin
                    o_fch_sqi_sck_en = 1'b1;
                    if (nib_cnt_q == 4'd5) begin
                        state_d   = ST_DUMMY;
                        nib_cnt_d = 4'd0;
                    end else begin
                        nib_cnt_d = nib_cnt_q + 4'd1;
                    end
                end
            end
            ST_DUMMY: begin
                o_fch_sqi_cs_n = 1'b0;
                if (!i_fch_stall) begin
                    o_fch_sqi_sck_en = 1'b1;
                    if (nib_cnt_q == DUMMY_LAST) begin
                        state_d   = ST_DATA;
                        nib_cnt_d = 4'd0;
                        wrd_cnt_d = 2'd0;
                    end else begin
                        nib_cnt_d = nib_cnt_q + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                o_fch_sqi_cs_n = 1'b0;
                if (!i_fch_stall) begin
                    o_fch_sqi_sck_en = 1'b1;
                    enc_d            = i_fch_sqi_rd;
                    vld_d            = 1'b1;
                    // pc travels with the nibble, so it is the address
                    // before any increment caused by this sample.
                    pc_d             = addr_q;
                    wrd_cnt_d        = wrd_cnt_q + 2'd1;
                    if (wrd_cnt_q == 2'd3) begin
                        addr_d = addr_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_DESEL;
            end
        endcase

        // Redirect beats stall and every state: close the burst, no SCK,
        // drop whatever sample would have been taken this cycle.
        if (i_fch_redirect) begin
            state_d          = ST_DESEL;
            nib_cnt_d        = 4'd0;
            wrd_cnt_d        = 2'd0;
            addr_d           = i_fch_redirect_pc;
            pc_d             = i_fch_redirect_pc;
            enc_d            = enc_q;
            vld_d            = 1'b0;
            o_fch_sqi_sck_en = 1'b0;
        end
    end

    assign o_fch_enc     = enc_q;
    assign o_fch_pc      = pc_q;
    // The nibble already registered when a redirect arrives is stale.
    assign o_fch_enc_vld = vld_q & ~i_fch_redirect;

endmodule

// File: tb/tb_idli_fetch_m.sv
// ---------------------------------------------------------------------------
// tb_idli_fetch_m -- self-checking bench for idli_fetch_m
//
// A behavioural SQI SRAM answers the DUT's bursts from a fixed memory image.
// Every time the bench starts a stream it pushes the nibbles it expects
// (word address + nibble position, read from the image) into a queue; a
// monitor pops and compares on every valid output nibble.
// ---------------------------------------------------------------------------
module tb_idli_fetch_m;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [7:0]  READ_CMD = 8'h03;
    localparam int          D        = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n, sck_en, oe;
    logic [3:0]  wr, sqi_rd, enc;
    logic        enc_vld;
    logic [15:0] pc;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;

    always #5 clk = ~clk;

    idli_fetch_m #(
        .RESET_PC     (RESET_PC),
        .READ_CMD     (READ_CMD),
        .DUMMY_CYCLES (D)
    ) dut (
        .i_fch_gck         (clk),
        .i_fch_rst         (rst),
        .o_fch_sqi_cs_n    (cs_n),
        .o_fch_sqi_sck_en  (sck_en),
        .o_fch_sqi_oe      (oe),
        .o_fch_sqi_wr      (wr),
        .i_fch_sqi_rd      (sqi_rd),
        .o_fch_enc         (enc),
        .o_fch_enc_vld     (enc_vld),
        .o_fch_pc          (pc),
        .i_fch_stall       (stall),
        .i_fch_redirect    (redirect),
        .i_fch_redirect_pc (redirect_pc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0]  nib;
        logic [15:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] exp_start = RESET_PC;
    logic        rand_stall_en = 1'b0;

    // Memory image: word 0 is fixed, the rest is a simple hash of the address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'hC123;
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [3:0] stream_nib(input logic [15:0] start, input int k);
        logic [15:0] d;
        d = mem_word(start + 16'(k / 4));
        return 4'(d >> (4 * (3 - (k % 4))));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_stream(input logic [15:0] start, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.nib = stream_nib(start, k);
            e.pc  = start + 16'(k / 4);
            exp_q.push_back(e);
        end
    endtask

    // -------------------------------------------------------------------
    // SRAM model: counts SCK cycles within a chip-select window; the first
    // 8 carry command+address in, D are turnaround, the rest are data out.
    // -------------------------------------------------------------------
    int          sram_cnt = 0;
    logic [31:0] sram_sh  = 32'h0;
    int          bursts   = 0;
    int          sr_k;
    logic [15:0] sr_w;

    always @(posedge clk) begin
        if (cs_n) begin
            sram_cnt <= 0;
        end else if (sck_en) begin
            if (sram_cnt < 8) begin
                chk("sqi_oe_during_cmd_addr", oe, 1'b1);
                sram_sh <= {sram_sh[27:0], wr};
            end else begin
                chk("sqi_oe_during_dummy_data", oe, 1'b0);
            end
            if (sram_cnt == 7) begin
                chk("sqi_cmd_and_addr", {sram_sh[27:0], wr}, {READ_CMD, 7'b0, exp_start, 1'b0});
                bursts++;
            end
            sram_cnt <= sram_cnt + 1;
        end
    end

    always_comb begin
        sr_k   = sram_cnt - 8 - D;
        sr_w   = sram_sh[16:1];
        sqi_rd = 4'h0;
        if (!cs_n && sram_cnt >= 8 + D) begin
            sqi_rd = stream_nib(sr_w, sr_k);
        end
    end

    // -------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------
    always @(negedge clk) begin
        if (enc_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_nibble: got enc=%0h pc=%0h, required no valid nibble (t=%0t)",
                         enc, pc, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("enc_nibble", enc, mon_e.nib);
                chk("enc_pc", pc, mon_e.pc);
            end
        end
    end

    // Random stall, driven later in the cycle than directed stimulus so that
    // disabling it never races with the directed process.
    always @(posedge clk) begin
        #2;
        if (rand_stall_en) stall = ($urandom_range(0, 3) == 0);
    end

    // -------------------------------------------------------------------
    // Stimulus helpers (all leave the bench 1 time unit after a posedge)
    // -------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        exp_q.delete();
        exp_start   = target;
    endtask

    task automatic wait_empty(input int budget);
        int c;
        c = 0;
        step();
        while (exp_q.size() != 0 && c < budget) begin
            step();
            c++;
        end
        chk("stream_drained_in_time", exp_q.size(), 0);
    endtask

    task automatic wait_cnt(input int target, input int budget);
        int c;
        c = 0;
        while (sram_cnt != target && c < budget) begin
            step();
            c++;
        end
        chk("reached_sram_phase", sram_cnt, target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int b0;
        int c;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_sck_en", sck_en, 1'b0);
        chk("rst_oe", oe, 1'b0);
        chk("rst_wr", wr, 4'h0);
        chk("rst_enc_vld", enc_vld, 1'b0);
        chk("rst_enc", enc, 4'h0);
        chk("rst_pc", pc, RESET_PC);

        // Fetch from reset: C,1,2,3 at pc 0, then word 1, then half of word 2
        step();
        rst = 1'b0;
        push_stream(RESET_PC, 10);
        wait_empty(200);

        // Redirect mid-word, with exact timing of the restart
        start(16'h1234);
        push_stream(16'h1234, 8);
        @(negedge clk);
        chk("vld_low_in_redirect_cycle", enc_vld, 1'b0);
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("vld_low_after_redirect", enc_vld, 1'b0);
        chk("desel_after_redirect", cs_n, 1'b1);
        step();
        @(negedge clk);
        chk("desel_one_cycle_only", cs_n, 1'b0);
        lat = 2;
        while (!enc_vld && lat < 40) begin
            step();
            lat++;
            @(negedge clk);
        end
        chk("first_vld_cycle_after_desel_entry", lat, 13);
        wait_empty(200);

        // Stall for 3 cycles after the 2nd nibble of a word
        start(16'h0042);
        push_stream(16'h0042, 8);
        step();
        redirect = 1'b0;
        c = 0;
        while (exp_q.size() > 6 && c < 100) begin
            step();
            c++;
        end
        chk("second_nibble_seen", exp_q.size(), 6);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sck_gated_in_stall", sck_en, 1'b0);
            chk("cs_held_in_stall", cs_n, 1'b0);
            if (i > 0) chk("vld_low_after_stalled_cycle", enc_vld, 1'b0);
            step();
        end
        stall = 1'b0;
        wait_empty(200);

        // Redirect and stall together during ADDR: redirect wins
        start(16'h0ABC);
        step();
        redirect = 1'b0;
        wait_cnt(3, 100);
        start(16'h7777);
        stall = 1'b1;
        push_stream(16'h7777, 4);
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        @(negedge clk);
        chk("desel_after_redirect_with_stall", cs_n, 1'b1);
        wait_empty(200);

        // Back-to-back redirects: last target wins
        start(16'h1111);
        step();
        start(16'h2222);
        push_stream(16'h2222, 4);
        step();
        redirect = 1'b0;
        wait_empty(200);

        // Wrap from FFFF to 0000 inside one burst
        b0 = bursts;
        start(16'hFFFF);
        push_stream(16'hFFFF, 8);
        step();
        redirect = 1'b0;
        wait_empty(200);
        chk("single_burst_across_wrap", bursts - b0, 1);

        // Random targets and lengths with random stalls
        rand_stall_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [15:0] t;
            t = (i % 4 == 0) ? 16'(16'hFFFD + 16'($urandom_range(0, 3)))
                             : 16'($urandom_range(0, 65535));
            start(t);
            push_stream(t, $urandom_range(1, 12));
            step();
            redirect = 1'b0;
            wait_empty(500);
        end
        rand_stall_en = 1'b0;
        stall         = 1'b0;

        // Reset during DUMMY: clean restart from RESET_PC
        start(16'h0500);
        step();
        redirect = 1'b0;
        wait_cnt(8, 100);
        rst = 1'b1;
        exp_q.delete();
        exp_start = RESET_PC;
        push_stream(RESET_PC, 4);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_dummy_cs_n", cs_n, 1'b1);
        chk("reset_in_dummy_vld", enc_vld, 1'b0);
        chk("reset_in_dummy_pc", pc, RESET_PC);
        wait_empty(200);

        // Quiesce
        redirect = 1'b1;
        step();
        redirect = 1'b0;
        rst      = 1'b1;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
